// File: rtl/bj_pkg.sv
// Shared definitions for the branch/jump predict-and-resolve unit.
//   - bj_ctrl_e     : EX-stage branch/jump class (none, branch, JAL, JALR)
//   - F3_*          : FUNC3 encodings of the conditional branches
//   - SNT/WNT/WT/ST : 2-bit direction counter states
//   - sweep_state_e : table-invalidation sweep FSM states
//   - ctr_next()    : saturating direction-counter update
package bj_pkg;

    typedef enum logic [1:0] {
        BJ_NONE   = 2'b00,
        BJ_BRANCH = 2'b01,
        BJ_JAL    = 2'b10,
        BJ_JALR   = 2'b11
    } bj_ctrl_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_e;

    // Move one step toward the resolved direction, sticking at SNT / ST.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
        else       return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bj_cond_eval.sv
// Conditional-branch evaluator: maps FUNC3 and the ALU compare flags of
// rs1-rs2 to a taken decision. Purely combinational.
//   func3    in  branch type
//   zero     in  rs1 == rs2
//   sign_bit in  rs1 <  rs2 (signed)
//   sltu_bit in  rs1 <  rs2 (unsigned)
//   taken    out branch condition holds
module bj_cond_eval
    import bj_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       sign_bit,
    input  logic       sltu_bit,
    output logic       taken
);

    always_comb begin
        // NOTE: default first, so every path assigns taken and no latch is inferred.
        taken = 1'b0;
        case (func3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = sign_bit;
            F3_BGE:  taken = ~sign_bit;
            F3_BLTU: taken = sltu_bit;
            F3_BGEU: taken = ~sltu_bit;
            default: taken = 1'b0;   // 010/011 are not branches
        endcase
    end

endmodule

// File: rtl/bj_predict_unit.sv
// Branch/jump unit: tagged BTB lookup in IF, resolution and redirect in EX,
// table training, fence.i invalidation sweep and saturating perf counters.
//   CLK, RESETN                    clock, asynchronous active-low reset
//   CLEAR                          restart invalidation sweep
//   F_PC -> F_PRED_TAKEN/TARGET    combinational fetch prediction
//   E_* , BJ_CTRL, FUNC3, flags    EX-stage instruction and compare flags
//   REDIRECT, REDIRECT_PC          mispredict flush and correct next PC
//   BUSY                           sweep in progress
//   BRANCH_CNT, MISPRED_CNT        saturating resolve / redirect counts
module bj_predict_unit
    import bj_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CLEAR,
    input  logic [XLEN-1:0]  F_PC,
    output logic             F_PRED_TAKEN,
    output logic [XLEN-1:0]  F_PRED_TARGET,
    input  logic             E_VALID,
    input  logic [XLEN-1:0]  E_PC,
    input  logic [XLEN-1:0]  E_IMM,
    input  logic [XLEN-1:0]  E_JALR_TARGET,
    input  logic [1:0]       BJ_CTRL,
    input  logic [2:0]       FUNC3,
    input  logic             ZERO,
    input  logic             SIGN_BIT,
    input  logic             SLTU_BIT,
    input  logic             E_PRED_TAKEN,
    input  logic [XLEN-1:0]  E_PRED_TARGET,
    output logic             REDIRECT,
    output logic [XLEN-1:0]  REDIRECT_PC,
    output logic             BUSY,
    output logic [CNT_W-1:0] BRANCH_CNT,
    output logic [CNT_W-1:0] MISPRED_CNT
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BTB_DEPTH - 1);
    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0]  LSB_MASK = XLEN'(1);

    // BTB storage
    logic [BTB_DEPTH-1:0] tbl_valid;
    logic [BTB_DEPTH-1:0] tbl_jump;
    logic [1:0]           tbl_ctr    [BTB_DEPTH];
    logic [TAG_W-1:0]     tbl_tag    [BTB_DEPTH];
    logic [XLEN-1:0]      tbl_target [BTB_DEPTH];

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] sweep_idx;
    logic             busy;

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0] f_idx;
    logic             f_hit;
    logic             f_pc_unused;   // byte offset never selects an entry

    assign f_idx       = F_PC[IDX_W+1:2];
    assign f_pc_unused = ^F_PC[1:0];
    assign f_hit       = ~busy & tbl_valid[f_idx] & (tbl_tag[f_idx] == F_PC[XLEN-1:IDX_W+2]);

    // Reads the pre-edge table: an update to the same index this cycle is not bypassed.
    assign F_PRED_TAKEN  = f_hit & (tbl_jump[f_idx] | tbl_ctr[f_idx][1]);
    assign F_PRED_TARGET = f_hit ? tbl_target[f_idx] : '0;

    // ---------------- EX resolution ----------------
    bj_ctrl_e         ctrl;
    logic             cond_taken, resolve, act_taken, mispredict;
    logic [XLEN-1:0]  act_target;
    logic [IDX_W-1:0] e_idx;
    logic             e_hit, upd_en, alloc;

    assign ctrl = bj_ctrl_e'(BJ_CTRL);

    bj_cond_eval u_cond (
        .func3    (FUNC3),
        .zero     (ZERO),
        .sign_bit (SIGN_BIT),
        .sltu_bit (SLTU_BIT),
        .taken    (cond_taken)
    );

    assign resolve    = E_VALID & (ctrl != BJ_NONE);
    assign act_taken  = (ctrl == BJ_BRANCH) ? cond_taken : (ctrl == BJ_JAL || ctrl == BJ_JALR);
    assign act_target = (ctrl == BJ_JALR) ? (E_JALR_TARGET & ~LSB_MASK) : (E_PC + E_IMM);
    assign mispredict = (act_taken != E_PRED_TAKEN)
                      | (act_taken & E_PRED_TAKEN & (act_target != E_PRED_TARGET));

    assign REDIRECT    = resolve & mispredict;
    assign REDIRECT_PC = !REDIRECT ? '0 : (act_taken ? act_target : E_PC + PC_STEP);

    assign e_idx  = E_PC[IDX_W+1:2];
    assign e_hit  = tbl_valid[e_idx] & (tbl_tag[e_idx] == E_PC[XLEN-1:IDX_W+2]);
    assign upd_en = resolve & ~busy;
    assign alloc  = upd_en & (((ctrl == BJ_BRANCH) & ~e_hit & act_taken) | (ctrl == BJ_JAL));

    // ---------------- Table state ----------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            tbl_valid <= '0;
            tbl_jump  <= '0;
            // NOTE: only the control fields are reset; tag/target payload is
            // don't-care behind a cleared valid bit and stays reset-free RAM.
            for (int i = 0; i < BTB_DEPTH; i++) tbl_ctr[i] <= SNT;
        end else if (busy) begin
            tbl_valid[sweep_idx] <= 1'b0;
        end else if (upd_en) begin
            case (ctrl)
                BJ_BRANCH: begin
                    if (e_hit) begin
                        tbl_ctr[e_idx] <= ctr_next(tbl_ctr[e_idx], act_taken);
                    end else if (act_taken) begin
                        tbl_valid[e_idx] <= 1'b1;
                        tbl_jump[e_idx]  <= 1'b0;
                        tbl_ctr[e_idx]   <= WT;
                    end
                end
                BJ_JAL: begin
                    tbl_valid[e_idx] <= 1'b1;
                    tbl_jump[e_idx]  <= 1'b1;
                    tbl_ctr[e_idx]   <= WT;
                end
                BJ_JALR: begin
                    // Register-indirect targets are not cached; drop stale entries.
                    if (e_hit) tbl_valid[e_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (alloc) begin
            tbl_tag[e_idx]    <= E_PC[XLEN-1:IDX_W+2];
            tbl_target[e_idx] <= act_target;
        end
    end

    // ---------------- Sweep FSM ----------------
    always_ff @(posedge CLK or negedge RESETN) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RESETN) state_q <= ST_INIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (!CLEAR && sweep_idx == LAST_IDX) state_d = ST_RUN;
            ST_RUN:  if (CLEAR) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_INIT);
    end

    // Index wraps to 0 after the last entry, so RUN always restarts at 0.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)   sweep_idx <= '0;
        else if (CLEAR) sweep_idx <= '0;
        else if (busy)  sweep_idx <= sweep_idx + IDX_W'(1);
    end

    assign BUSY = busy;

    // ---------------- Performance counters ----------------
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            BRANCH_CNT  <= '0;
            MISPRED_CNT <= '0;
        end else begin
            if (resolve  && BRANCH_CNT  != '1) BRANCH_CNT  <= BRANCH_CNT  + CNT_W'(1);
            if (REDIRECT && MISPRED_CNT != '1) MISPRED_CNT <= MISPRED_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bj_predict_unit.sv
module tb_bj_predict_unit;

    logic        clk, rst_n, clear;
    logic [31:0] f_pc, e_pc, e_imm, e_jt, e_ptg;
    logic        e_valid, zero, sign_bit, sltu_bit, e_pt;
    logic [1:0]  bj_ctrl;
    logic [2:0]  func3;

    logic        f_pt, redirect, busy;
    logic [31:0] f_ptg, redirect_pc;
    logic [15:0] br_cnt, mp_cnt;

    logic        s_f_pt, s_redirect, s_busy;
    logic [31:0] s_f_ptg, s_redirect_pc;
    logic [3:0]  s_br_cnt, s_mp_cnt;

    int n_checks = 0;
    int n_errors = 0;

    bj_predict_unit dut (
        .CLK(clk), .RESETN(rst_n), .CLEAR(clear), .F_PC(f_pc),
        .F_PRED_TAKEN(f_pt), .F_PRED_TARGET(f_ptg),
        .E_VALID(e_valid), .E_PC(e_pc), .E_IMM(e_imm), .E_JALR_TARGET(e_jt),
        .BJ_CTRL(bj_ctrl), .FUNC3(func3), .ZERO(zero), .SIGN_BIT(sign_bit),
        .SLTU_BIT(sltu_bit), .E_PRED_TAKEN(e_pt), .E_PRED_TARGET(e_ptg),
        .REDIRECT(redirect), .REDIRECT_PC(redirect_pc), .BUSY(busy),
        .BRANCH_CNT(br_cnt), .MISPRED_CNT(mp_cnt)
    );

    // Narrow-counter copy for the saturation boundary.
    bj_predict_unit #(.CNT_W(4)) u_sat (
        .CLK(clk), .RESETN(rst_n), .CLEAR(clear), .F_PC(f_pc),
        .F_PRED_TAKEN(s_f_pt), .F_PRED_TARGET(s_f_ptg),
        .E_VALID(e_valid), .E_PC(e_pc), .E_IMM(e_imm), .E_JALR_TARGET(e_jt),
        .BJ_CTRL(bj_ctrl), .FUNC3(func3), .ZERO(zero), .SIGN_BIT(sign_bit),
        .SLTU_BIT(sltu_bit), .E_PRED_TAKEN(e_pt), .E_PRED_TARGET(e_ptg),
        .REDIRECT(s_redirect), .REDIRECT_PC(s_redirect_pc), .BUSY(s_busy),
        .BRANCH_CNT(s_br_cnt), .MISPRED_CNT(s_mp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    typedef struct {
        bit          valid;
        bit          jump;
        int unsigned tag;
        bit [31:0]   target;
        int          ctr;      // 0..3, taken prediction when >= 2
    } ent_t;

    ent_t tbl [64];
    int   busy_left;
    int   bcnt, mcnt;

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) tbl[i].valid = 1'b0;
        busy_left = 64;
        bcnt = 0;
        mcnt = 0;
    endtask

    // Resolution of the instruction currently on the EX inputs.
    task automatic m_resolve(output bit tk, output bit [31:0] tgt,
                             output bit red, output bit [31:0] rpc);
        bit c;
        case (func3)
            3'd0: c = zero;       3'd1: c = !zero;
            3'd4: c = sign_bit;   3'd5: c = !sign_bit;
            3'd6: c = sltu_bit;   3'd7: c = !sltu_bit;
            default: c = 1'b0;
        endcase
        tk  = (bj_ctrl == 2'd1) ? c : (bj_ctrl >= 2'd2);
        tgt = (bj_ctrl == 2'd3) ? (e_jt & 32'hFFFF_FFFE) : e_pc + e_imm;
        red = e_valid && bj_ctrl != 2'd0 && (tk != e_pt || (tk && tgt != e_ptg));
        rpc = !red ? 32'd0 : (tk ? tgt : e_pc + 32'd4);
    endtask

    task automatic model_step();
        bit tk, red, bsy, hit;
        bit [31:0] tgt, rpc;
        int i;
        int unsigned tg;
        if (!rst_n) begin
            model_reset();
            return;
        end
        bsy = busy_left > 0;
        m_resolve(tk, tgt, red, rpc);
        if (e_valid && bj_ctrl != 2'd0) begin
            bcnt++;
            if (red) mcnt++;
            if (!bsy) begin
                i   = int'((e_pc >> 2) % 64);
                tg  = e_pc >> 8;
                hit = tbl[i].valid && tbl[i].tag == tg;
                case (bj_ctrl)
                    2'd1: begin
                        if (hit) begin
                            if (tk && tbl[i].ctr < 3) tbl[i].ctr++;
                            if (!tk && tbl[i].ctr > 0) tbl[i].ctr--;
                        end else if (tk) begin
                            tbl[i] = '{valid: 1'b1, jump: 1'b0, tag: tg, target: tgt, ctr: 2};
                        end
                    end
                    2'd2: tbl[i] = '{valid: 1'b1, jump: 1'b1, tag: tg, target: tgt, ctr: 2};
                    default: if (hit) tbl[i].valid = 1'b0;
                endcase
            end
        end
        if (clear) begin
            busy_left = 64;
            for (int k = 0; k < 64; k++) tbl[k].valid = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    task automatic compare();
        bit tk, red, bsy, hit, pt;
        bit [31:0] tgt, rpc, ptg;
        int i;
        bsy = busy_left > 0;
        i   = int'((f_pc >> 2) % 64);
        hit = !bsy && tbl[i].valid && tbl[i].tag == (f_pc >> 8);
        pt  = hit && (tbl[i].jump || tbl[i].ctr >= 2);
        ptg = hit ? tbl[i].target : 32'd0;
        m_resolve(tk, tgt, red, rpc);
        check("busy",          32'(busy),     32'(bsy));
        check("f_pred_taken",  32'(f_pt),     32'(pt));
        check("f_pred_target", f_ptg,         ptg);
        check("redirect",      32'(redirect), 32'(red));
        check("redirect_pc",   redirect_pc,   rpc);
        check("branch_cnt",    32'(br_cnt),   32'(sat(bcnt, 65535)));
        check("mispred_cnt",   32'(mp_cnt),   32'(sat(mcnt, 65535)));
        check("sat_branch_cnt",  32'(s_br_cnt), 32'(sat(bcnt, 15)));
        check("sat_mispred_cnt", 32'(s_mp_cnt), 32'(sat(mcnt, 15)));
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst_n) compare();
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- Directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        bj_ctrl = 2'd0;
        clear   = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ctrl, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] jt, input logic z,
                         input logic s, input logic u, input logic pt, input logic [31:0] ptg);
        e_valid = 1'b1; bj_ctrl = ctrl; func3 = f3; e_pc = pc; e_imm = imm; e_jt = jt;
        zero = z; sign_bit = s; sltu_bit = u; e_pt = pt; e_ptg = ptg;
    endtask

    task automatic count_busy(input string name);
        int  nb = 0;
        bit  done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (f_pt) check({name, "_no_pred"}, 32'(f_pt), 32'd0);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            nb++;
        end
        check({name, "_cycles"}, 32'(nb), 32'd64);
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        bit [7:0] exp_a, exp_b;
        rst_n = 1'b0; clear = 1'b0; f_pc = 32'h0; e_valid = 1'b0; bj_ctrl = 2'd0;
        func3 = 3'd0; e_pc = 32'h0; e_imm = 32'h0; e_jt = 32'h0; zero = 1'b0;
        sign_bit = 1'b0; sltu_bit = 1'b0; e_pt = 1'b0; e_ptg = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset release: sweep lasts exactly 64 cycles.
        count_busy("reset_busy");
        check("reset_branch_cnt", 32'(br_cnt), 32'd0);
        check("reset_mispred_cnt", 32'(mp_cnt), 32'd0);
        next_cycle();

        // BEQ taken, predicted not taken; same-cycle lookup sees no entry.
        f_pc = 32'h100;
        drive(2'd1, 3'd0, 32'h100, 32'h40, 32'h0, 1, 0, 0, 0, 32'h0);
        sample();
        check("beq_redirect", 32'(redirect), 32'd1);
        check("beq_redirect_pc", redirect_pc, 32'h140);
        check("beq_no_bypass", 32'(f_pt), 32'd0);
        next_cycle(); sample();
        check("beq_alloc_pred", 32'(f_pt), 32'd1);
        check("beq_alloc_target", f_ptg, 32'h140);

        // Not taken three times: 10 -> 01 -> 00 -> 00.
        next_cycle();
        drive(2'd1, 3'd0, 32'h100, 32'h40, 32'h0, 0, 0, 0, 1, 32'h140);
        sample();
        check("nt1_redirect_pc", redirect_pc, 32'h104);
        next_cycle(); sample();
        check("nt1_pred", 32'(f_pt), 32'd0);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            drive(2'd1, 3'd0, 32'h100, 32'h40, 32'h0, 0, 0, 0, 0, 32'h0);
            sample();
            check("nt_agree_redirect", 32'(redirect), 32'd0);
        end
        // Two taken resolutions from 00: still not predicted after the first.
        next_cycle();
        drive(2'd1, 3'd0, 32'h100, 32'h40, 32'h0, 1, 0, 0, 0, 32'h0);
        next_cycle(); sample();
        check("sat_low_pred", 32'(f_pt), 32'd0);
        drive(2'd1, 3'd0, 32'h100, 32'h40, 32'h0, 1, 0, 0, 0, 32'h0);
        next_cycle(); sample();
        check("retrain_pred", 32'(f_pt), 32'd1);

        // Aliasing on the same index with a different tag.
        f_pc = 32'h200; sample();
        check("alias_pred", 32'(f_pt), 32'd0);

        // JALR never allocates; target LSB cleared.
        next_cycle();
        drive(2'd3, 3'd0, 32'h200, 32'h0, 32'h305, 0, 0, 0, 0, 32'h0);
        sample();
        check("jalr_redirect_pc", redirect_pc, 32'h304);
        next_cycle(); sample();
        check("jalr_no_alloc", 32'(f_pt), 32'd0);

        // JAL allocation, correct prediction, wrong target, then JALR invalidation.
        drive(2'd2, 3'd0, 32'h300, 32'hFFFF_FF00, 32'h0, 0, 0, 0, 0, 32'h0);
        sample();
        check("jal_redirect_pc", redirect_pc, 32'h200);
        next_cycle(); f_pc = 32'h300; sample();
        check("jal_pred", 32'(f_pt), 32'd1);
        check("jal_pred_target", f_ptg, 32'h200);
        drive(2'd2, 3'd0, 32'h300, 32'hFFFF_FF00, 32'h0, 0, 0, 0, 1, 32'h200);
        sample();
        check("jal_hit_no_redirect", 32'(redirect), 32'd0);
        next_cycle();
        drive(2'd2, 3'd0, 32'h300, 32'hFFFF_FF00, 32'h0, 0, 0, 0, 1, 32'h204);
        sample();
        check("jal_bad_target", 32'(redirect), 32'd1);
        next_cycle();
        drive(2'd3, 3'd0, 32'h300, 32'h0, 32'h201, 0, 0, 0, 1, 32'h200);
        sample();
        check("jalr_match_no_redirect", 32'(redirect), 32'd0);
        next_cycle(); sample();
        check("jalr_invalidate", 32'(f_pt), 32'd0);

        // Every FUNC3 under two opposite flag patterns.
        exp_a = 8'b0110_0001;   // z=1 s=0 u=1
        exp_b = 8'b1001_0010;   // z=0 s=1 u=0
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            drive(2'd1, 3'(k), 32'h400 + 32'(k * 4), 32'h8, 32'h0, 1, 0, 1, 0, 32'h0);
            sample();
            check("f3_a_redirect", 32'(redirect), 32'(exp_a[k]));
        end
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            drive(2'd1, 3'(k), 32'h480 + 32'(k * 4), 32'h8, 32'h0, 0, 1, 0, 1,
                  32'h488 + 32'(k * 4));
            sample();
            check("f3_b_redirect", 32'(redirect), 32'(!exp_b[k]));
        end

        // PC wrap-around.
        next_cycle();
        drive(2'd1, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'h0, 0, 0, 0, 1, 32'h4);
        sample();
        check("wrap_nt_redirect", 32'(redirect), 32'd1);
        check("wrap_nt_pc", redirect_pc, 32'h0);
        next_cycle();
        drive(2'd1, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1, 0, 0, 0, 32'h0);
        sample();
        check("wrap_tk_pc", redirect_pc, 32'h4);

        // CLEAR sweep with a branch resolving during it.
        next_cycle(); clear = 1'b1;
        next_cycle(); f_pc = 32'h500;
        drive(2'd1, 3'd1, 32'h500, 32'h10, 32'h0, 0, 0, 0, 0, 32'h0);
        sample();
        check("sweep_busy", 32'(busy), 32'd1);
        check("sweep_redirect_pc", redirect_pc, 32'h510);
        repeat (5) next_cycle();
        clear = 1'b1;
        next_cycle();
        count_busy("restart_busy");
        next_cycle(); sample();
        check("sweep_dropped_update", 32'(f_pt), 32'd0);
        f_pc = 32'h480; sample();
        check("sweep_cleared", 32'(f_pt), 32'd0);
        check("sat_branch_hold", 32'(s_br_cnt), 32'hF);

        // Allocate, then reset mid-update: nothing survives.
        drive(2'd1, 3'd0, 32'h600, 32'h20, 32'h0, 1, 0, 0, 0, 32'h0);
        next_cycle(); f_pc = 32'h600; sample();
        check("post_sweep_alloc", 32'(f_pt), 32'd1);
        next_cycle();
        drive(2'd2, 3'd0, 32'h700, 32'h40, 32'h0, 0, 0, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_branch_cnt", 32'(br_cnt), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd1);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        count_busy("rst2_busy");
        next_cycle(); sample();
        check("rst_cleared_600", 32'(f_pt), 32'd0);
        f_pc = 32'h700; sample();
        check("rst_no_partial_700", 32'(f_pt), 32'd0);
        check("rst_sat_cnt", 32'(s_br_cnt), 32'd0);

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bj_predict_unit.md
Name: bj_predict_unit

Overview:
- Parametrised next-generation branch/jump unit for the RV32IM pipeline.
- Sits across IF (prediction lookup) and EX (resolution).
- Holds a tagged BTB with 2-bit saturating direction counters.
- Evaluates branch conditions from ALU flags, detects mispredictions, drives the redirect/flush PC, updates its tables and keeps saturating performance counters.

Parameters:
XLEN, 32, datapath/PC width
BTB_DEPTH, 64, BTB entries; power of two, minimum 4
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  clock, rising edge
RESETN  in  1  asynchronous active-low reset
CLEAR  in  1  restart table-invalidation sweep (fence.i)
F_PC  in  XLEN  fetch PC
F_PRED_TAKEN  out  1  predicted taken for F_PC
F_PRED_TARGET  out  XLEN  predicted target for F_PC
E_VALID  in  1  EX holds a valid instruction this cycle
E_PC  in  XLEN  EX instruction PC
E_IMM  in  XLEN  sign-extended B/J immediate
E_JALR_TARGET  in  XLEN  ALU rs1+imm result for JALR
BJ_CTRL  in  2  00 none, 01 branch, 10 JAL, 11 JALR
FUNC3  in  3  branch type
ZERO, SIGN_BIT, SLTU_BIT  in  1 each  ALU compare flags for rs1-rs2
E_PRED_TAKEN  in  1  prediction piped down with the instruction
E_PRED_TARGET  in  XLEN  predicted target piped down
REDIRECT  out  1  mispredict; flush IF/ID, load REDIRECT_PC
REDIRECT_PC  out  XLEN  correct next PC
BUSY  out  1  invalidation sweep in progress
BRANCH_CNT  out  CNT_W  resolved branches/jumps
MISPRED_CNT  out  CNT_W  redirects issued

Behaviour:
- Index = PC[log2(BTB_DEPTH)+1:2]; tag = PC[XLEN-1:log2(BTB_DEPTH)+2].
- Entry fields: valid, jump bit, tag, target, 2-bit counter.
- Lookup is combinational. F_PRED_TAKEN = valid & tag match & (jump | ctr[1]); F_PRED_TARGET = entry target.
- F_PRED_TAKEN is forced 0 while BUSY.
- Conditions (combinational):
  - BEQ (000) = ZERO; BNE (001) = ~ZERO
  - BLT (100) = SIGN_BIT; BGE (101) = ~SIGN_BIT
  - BLTU (110) = SLTU_BIT; BGEU (111) = ~SLTU_BIT
  - FUNC3 010/011 -> not taken.
- Actual taken = branch ? cond : (BJ_CTRL==10 or 11).
- Actual target: PC+IMM for branch/JAL; E_JALR_TARGET & ~1 for JALR.
- REDIRECT is combinational and only when E_VALID & BJ_CTRL!=00. It asserts when:
  - actual taken != E_PRED_TAKEN, or
  - both taken and target != E_PRED_TARGET.
- REDIRECT_PC = taken ? target : E_PC+4. All adds wrap modulo 2^XLEN. REDIRECT_PC is 0 when REDIRECT=0.
- Table update on the clock edge after resolve (E_VALID & BJ_CTRL!=00 & ~BUSY):
  - Branch, hit: counter increments if taken, decrements if not; saturates at 00/11.
  - Branch, miss, taken: allocate; tag, target, ctr=10, jump=0.
  - Branch, miss, not taken: no change.
  - JAL: allocate/overwrite with jump=1 and target.
  - JALR: invalidate any hitting entry; never allocate.
- Same-cycle lookup and update on one index: lookup returns the pre-update value (no bypass).
- Sweep FSM, states INIT and RUN:
  - Reset enters INIT with sweep index 0. INIT clears one valid bit per cycle.
  - INIT -> RUN after index BTB_DEPTH-1 is cleared, so BUSY is high for exactly BTB_DEPTH cycles after RESETN deasserts.
  - CLEAR in RUN -> INIT at index 0. CLEAR during INIT restarts the index at 0.
  - Table updates are dropped during INIT. Resolution, REDIRECT and performance counters still operate.
- Performance counters:
  - BRANCH_CNT increments on each resolve; MISPRED_CNT increments on each REDIRECT.
  - Both saturate at all-ones and are cleared only by reset, not by CLEAR.
- Reset values: all entries invalid, counters 00, BUSY=1, BRANCH_CNT=0, MISPRED_CNT=0. Combinational outputs are 0 when BUSY with E_VALID=0.
- Reset asserted mid-sweep or mid-update aborts immediately; no partial write survives.

Decomposition:
- Shared package bj_pkg holds:
  - BJ_CTRL encodings (BJ_NONE, BJ_BRANCH, BJ_JAL, BJ_JALR)
  - FUNC3 branch codes
  - counter constants (SNT=00, WNT=01, WT=10, ST=11)
  - FSM state enum (ST_INIT, ST_RUN)
- One sub-module, bj_cond_eval: combinational FUNC3/flag -> taken evaluator, reusable by other EX logic.

Test Plan:
- Reset release -> BUSY high exactly 64 cycles, then 0; BRANCH_CNT=MISPRED_CNT=0; F_PRED_TAKEN=0 throughout.
- BEQ at PC 0x100, IMM 0x40, ZERO=1, E_PRED_TAKEN=0 -> REDIRECT=1, REDIRECT_PC=0x140. Next cycle, F_PC=0x100 -> F_PRED_TAKEN=1, F_PRED_TARGET=0x140.
- Same BEQ resolved not-taken three times after allocation -> counter 10->01->00->00. F_PRED_TAKEN=0 after the first. REDIRECTs issued only where prediction disagreed.
- JALR at PC 0x200, E_JALR_TARGET=0x305, pred not taken -> REDIRECT_PC=0x304, no BTB allocation (F_PC=0x200 still not predicted).
- Aliasing: PC 0x100 allocated, then F_PC=0x100+64*4 -> tag mismatch, F_PRED_TAKEN=0.
- CLEAR pulse with branch resolving during sweep -> REDIRECT correct, counters increment, table unchanged after sweep. Force BRANCH_CNT near 0xFFFF -> holds at 0xFFFF.
